// File: rtl/pht_sram_ctrl.sv
// Pattern history table controller: owns both ports of a 2-port 2-bit-counter
// SRAM, sweeps it to a known value after reset, serves 1-cycle lookups on
// port 0 and runs queued read-modify-write counter updates on port 1 with
// forwarding of recent port-1 writes.
module pht_sram_ctrl #(
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned UPD_DEPTH   = 4,
  parameter logic [1:0]  INIT_CTR    = 2'b01
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   init_done,
  input  logic                   pred_valid,
  input  logic [INDEX_WIDTH-1:0] pred_index,
  output logic                   pred_resp_valid,
  output logic [1:0]             pred_ctr,
  output logic                   pred_taken,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [INDEX_WIDTH-1:0] upd_index,
  input  logic                   upd_taken,
  output logic                   sram0_csb,
  output logic                   sram0_web,
  output logic [INDEX_WIDTH-1:0] sram0_addr,
  output logic [1:0]             sram0_din,
  input  logic [1:0]             sram0_dout,
  output logic                   sram1_csb,
  output logic                   sram1_web,
  output logic [INDEX_WIDTH-1:0] sram1_addr,
  output logic [1:0]             sram1_din,
  input  logic [1:0]             sram1_dout
);

  localparam int unsigned SWEEP_W = INDEX_WIDTH - 1;
  localparam int unsigned PTR_W   = $clog2(UPD_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam logic [SWEEP_W-1:0] SWEEP_LAST = '1;

  typedef enum logic [1:0] {S_INIT, S_DRAIN, S_RUN} top_e;
  typedef enum logic [1:0] {U_IDLE, U_RD, U_WR} upd_e;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] idx;
    logic                   taken;
  } upd_t;

  top_e                   top_q, top_d;
  logic [SWEEP_W-1:0]     sweep_q, sweep_d;
  logic                   drain_q, drain_d;
  upd_e                   ust_q, ust_d;
  upd_t                   cur_q, cur_d;
  upd_t                   fifo_q [UPD_DEPTH];
  upd_t                   fifo_d [UPD_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   hist_vld_q, hist_vld_d;
  logic [INDEX_WIDTH-1:0] hist_idx_q, hist_idx_d;
  logic [1:0]             hist_val_q, hist_val_d;
  logic                   fwd0_hit_q, fwd0_hit_d;
  logic [1:0]             fwd0_val_q, fwd0_val_d;
  logic                   fwd1_hit_q, fwd1_hit_d;
  logic [1:0]             fwd1_val_q, fwd1_val_d;
  logic                   pred_resp_valid_q, pred_resp_valid_d;
  logic                   upd_ready_q, upd_ready_d;
  logic                   init_done_q, init_done_d;

  logic                   run;
  logic                   sweeping;
  logic                   rd0;
  logic                   rd1;
  logic                   wr1;
  logic                   push;
  logic                   pop;
  logic [1:0]             upd_data1;
  logic [1:0]             new_ctr;

  // Saturating 2-bit counter step
  function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic t);
    logic [1:0] r;
    if (t) r = (c == 2'b11) ? 2'b11 : c + 2'b01;
    else   r = (c == 2'b00) ? 2'b00 : c - 2'b01;
    return r;
  endfunction

  // Per-cycle request decode and the RMW write value
  always_comb begin
    run       = (top_q == S_RUN);
    sweeping  = (top_q == S_INIT);
    rd0       = run && pred_valid;
    rd1       = run && (ust_q == U_RD);
    wr1       = run && (ust_q == U_WR);
    push      = upd_valid && upd_ready_q;
    pop       = run && (cnt_q != '0) && ((ust_q == U_IDLE) || (ust_q == U_WR));
    upd_data1 = fwd1_hit_q ? fwd1_val_q : sram1_dout;
    new_ctr   = sat_ctr(upd_data1, cur_q.taken);
  end

  // SRAM ports are driven in the request cycle so data returns one cycle later
  always_comb begin
    sram0_csb  = rst || !(sweeping || rd0);
    sram0_web  = rst || !sweeping;
    sram0_addr = sweeping ? {sweep_q, 1'b0} : pred_index;
    sram0_din  = INIT_CTR;
    sram1_csb  = rst || !(sweeping || rd1 || wr1);
    sram1_web  = rst || !(sweeping || wr1);
    sram1_addr = sweeping ? {sweep_q, 1'b1} : cur_q.idx;
    sram1_din  = sweeping ? INIT_CTR : new_ctr;
  end

  // Next-state logic for sweep, update engine, FIFO and forwarding history
  always_comb begin
    top_d             = top_q;
    sweep_d           = sweep_q;
    drain_d           = drain_q;
    ust_d             = ust_q;
    cur_d             = cur_q;
    fifo_d            = fifo_q;
    rd_ptr_d          = rd_ptr_q;
    wr_ptr_d          = wr_ptr_q;
    cnt_d             = cnt_q;
    hist_vld_d        = wr1;
    hist_idx_d        = cur_q.idx;
    hist_val_d        = new_ctr;
    fwd0_hit_d        = 1'b0;
    fwd0_val_d        = 2'b00;
    fwd1_hit_d        = 1'b0;
    fwd1_val_d        = 2'b00;
    pred_resp_valid_d = rd0;

    unique case (top_q)
      S_INIT: begin
        if (sweep_q == SWEEP_LAST) begin
          top_d   = S_DRAIN;
          sweep_d = '0;
          drain_d = 1'b0;
        end else begin
          sweep_d = sweep_q + SWEEP_W'(1);
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) top_d = S_RUN;
      end
      S_RUN:   top_d = S_RUN;
      default: top_d = S_INIT;
    endcase

    unique case (ust_q)
      U_IDLE:  if (pop) ust_d = U_RD;
      U_RD:    ust_d = U_WR;
      U_WR:    ust_d = pop ? U_RD : U_IDLE;
      default: ust_d = U_IDLE;
    endcase

    if (pop) begin
      cur_d    = fifo_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      fifo_d[wr_ptr_q] = '{idx: upd_index, taken: upd_taken};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    // A write issued this cycle is younger than the one held in history
    if (rd0) begin
      if (wr1 && (cur_q.idx == pred_index)) begin
        fwd0_hit_d = 1'b1;
        fwd0_val_d = new_ctr;
      end else if (hist_vld_q && (hist_idx_q == pred_index)) begin
        fwd0_hit_d = 1'b1;
        fwd0_val_d = hist_val_q;
      end
    end
    if (rd1 && hist_vld_q && (hist_idx_q == cur_q.idx)) begin
      fwd1_hit_d = 1'b1;
      fwd1_val_d = hist_val_q;
    end

    upd_ready_d = (top_d == S_RUN) && (cnt_d != CNT_W'(UPD_DEPTH));
    init_done_d = (top_d == S_RUN);
  end

  // State registers; reset drops all queued and in-flight work
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q             <= S_INIT;
      sweep_q           <= '0;
      drain_q           <= 1'b0;
      ust_q             <= U_IDLE;
      cur_q             <= '0;
      fifo_q            <= '{default: '0};
      rd_ptr_q          <= '0;
      wr_ptr_q          <= '0;
      cnt_q             <= '0;
      hist_vld_q        <= 1'b0;
      hist_idx_q        <= '0;
      hist_val_q        <= 2'b00;
      fwd0_hit_q        <= 1'b0;
      fwd0_val_q        <= 2'b00;
      fwd1_hit_q        <= 1'b0;
      fwd1_val_q        <= 2'b00;
      pred_resp_valid_q <= 1'b0;
      upd_ready_q       <= 1'b0;
      init_done_q       <= 1'b0;
    end else begin
      top_q             <= top_d;
      sweep_q           <= sweep_d;
      drain_q           <= drain_d;
      ust_q             <= ust_d;
      cur_q             <= cur_d;
      fifo_q            <= fifo_d;
      rd_ptr_q          <= rd_ptr_d;
      wr_ptr_q          <= wr_ptr_d;
      cnt_q             <= cnt_d;
      hist_vld_q        <= hist_vld_d;
      hist_idx_q        <= hist_idx_d;
      hist_val_q        <= hist_val_d;
      fwd0_hit_q        <= fwd0_hit_d;
      fwd0_val_q        <= fwd0_val_d;
      fwd1_hit_q        <= fwd1_hit_d;
      fwd1_val_q        <= fwd1_val_d;
      pred_resp_valid_q <= pred_resp_valid_d;
      upd_ready_q       <= upd_ready_d;
      init_done_q       <= init_done_d;
    end
  end

  assign init_done       = init_done_q;
  assign upd_ready       = upd_ready_q;
  assign pred_resp_valid = pred_resp_valid_q;
  assign pred_ctr        = pred_resp_valid_q ? (fwd0_hit_q ? fwd0_val_q : sram0_dout) : 2'b00;
  assign pred_taken      = pred_ctr[1];

endmodule

// File: tb/tb_pht_sram_ctrl.sv
// Bench for pht_sram_ctrl: behavioural 2-port SRAM with delayed write
// visibility, and a reference table updated atomically at each write cycle.
module tb_pht_sram_ctrl;

  localparam int RUN_CYC = 131;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done;
  logic       pred_valid;
  logic [7:0] pred_index;
  logic       pred_resp_valid;
  logic [1:0] pred_ctr;
  logic       pred_taken;
  logic       upd_valid;
  logic       upd_ready;
  logic [7:0] upd_index;
  logic       upd_taken;
  logic       sram0_csb, sram0_web, sram1_csb, sram1_web;
  logic [7:0] sram0_addr, sram1_addr;
  logic [1:0] sram0_din, sram1_din;
  logic [1:0] sram0_dout = 2'b00;
  logic [1:0] sram1_dout = 2'b00;

  pht_sram_ctrl #(.INDEX_WIDTH(8), .UPD_DEPTH(4), .INIT_CTR(2'b01)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .pred_valid(pred_valid), .pred_index(pred_index),
    .pred_resp_valid(pred_resp_valid), .pred_ctr(pred_ctr), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index), .upd_taken(upd_taken),
    .sram0_csb(sram0_csb), .sram0_web(sram0_web), .sram0_addr(sram0_addr),
    .sram0_din(sram0_din), .sram0_dout(sram0_dout),
    .sram1_csb(sram1_csb), .sram1_web(sram1_web), .sram1_addr(sram1_addr),
    .sram1_din(sram1_din), .sram1_dout(sram1_dout)
  );

  always #5 clk = ~clk;

  // SRAM model: read data next cycle; a write lands in the array one cycle
  // late, so it is only seen by reads issued two or more cycles after it.
  logic [1:0] mem [256];
  logic       seeded = 1'b0;
  logic       p0_v = 1'b0, p1_v = 1'b0;
  logic [7:0] p0_a, p1_a;
  logic [1:0] p0_d, p1_d;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 2'($urandom_range(3, 0));
      seeded <= 1'b1;
    end else begin
      if (p0_v) mem[p0_a] <= p0_d;
      if (p1_v) mem[p1_a] <= p1_d;
    end
    if (!sram0_csb) sram0_dout <= mem[sram0_addr];
    if (!sram1_csb) sram1_dout <= mem[sram1_addr];
    p0_v <= !sram0_csb && !sram0_web;
    p0_a <= sram0_addr;
    p0_d <= sram0_din;
    p1_v <= !sram1_csb && !sram1_web;
    p1_a <= sram1_addr;
    p1_d <= sram1_din;
  end

  // Reference model
  typedef struct {
    logic [7:0] idx;
    logic       taken;
  } upd_s;

  upd_s       q[$];
  logic [1:0] ref_tbl [256];
  int         mc;
  int         stage;   // 0: engine free, 1: reading, 2: writing
  logic [7:0] cur_i;
  logic       cur_t;
  int         n_checks = 0;
  int         n_fail = 0;
  logic       acc;
  logic [7:0] b_idx [12];
  logic       b_t [12];
  int         k;

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  function automatic void model_reset();
    q.delete();
    stage = 0;
    cur_i = 8'h00;
    cur_t = 1'b0;
    for (int i = 0; i < 256; i++) ref_tbl[i] = 2'b01;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, mc);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, advance the model,
  // then check the lookup response just after the rising edge.
  task automatic cyc(input logic pv, input logic [7:0] pi, input logic uv,
                     input logic [7:0] ui, input logic ut, output logic accepted);
    logic       run, rdy, nv;
    logic [1:0] nexp;
    upd_s       e;
    pred_valid = pv; pred_index = pi;
    upd_valid  = uv; upd_index  = ui; upd_taken = ut;
    run = (mc >= RUN_CYC);
    rdy = run && (q.size() < 4);
    chk("init_done", 32'(init_done), 32'(run));
    chk("upd_ready", 32'(upd_ready), 32'(rdy));
    if (run && stage == 2) ref_tbl[cur_i] = sat(ref_tbl[cur_i], cur_t);
    nv   = run && pv;
    nexp = ref_tbl[pi];
    if (run) begin
      if ((stage == 0 || stage == 2) && q.size() > 0) begin
        e = q.pop_front();
        cur_i = e.idx;
        cur_t = e.taken;
        stage = 1;
      end else if (stage == 1) begin
        stage = 2;
      end else begin
        stage = 0;
      end
    end
    accepted = uv && rdy;
    if (accepted) begin
      e.idx = ui;
      e.taken = ut;
      q.push_back(e);
    end
    mc++;
    @(posedge clk);
    #1;
    chk("pred_resp_valid", 32'(pred_resp_valid), 32'(nv));
    if (nv) begin
      chk("pred_ctr", 32'(pred_ctr), 32'(nexp));
      chk("pred_taken", 32'(pred_taken), 32'(nexp[1]));
    end
    @(negedge clk);
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, a);
  endtask

  task automatic look(input logic [7:0] idx);
    logic a;
    cyc(1'b1, idx, 1'b0, 8'h00, 1'b0, a);
  endtask

  task automatic upd(input logic [7:0] idx, input logic t);
    logic a;
    cyc(1'b0, 8'h00, 1'b1, idx, t, a);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_init_done"}, 32'(init_done), 32'(0));
    chk({tag, "_upd_ready"}, 32'(upd_ready), 32'(0));
    chk({tag, "_pred_resp_valid"}, 32'(pred_resp_valid), 32'(0));
    chk({tag, "_pred_ctr"}, 32'(pred_ctr), 32'(0));
    chk({tag, "_sram0_csb"}, 32'(sram0_csb), 32'(1));
    chk({tag, "_sram0_web"}, 32'(sram0_web), 32'(1));
    chk({tag, "_sram1_csb"}, 32'(sram1_csb), 32'(1));
    chk({tag, "_sram1_web"}, 32'(sram1_web), 32'(1));
  endtask

  initial begin
    rst = 1'b1;
    pred_valid = 1'b0; pred_index = 8'h00;
    upd_valid = 1'b0; upd_index = 8'h00; upd_taken = 1'b0;
    model_reset();
    mc = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;
    mc = 1;

    // Sweep and drain: lookups and updates offered here must be ignored
    for (int i = 0; i < 130; i++)
      cyc(1'($urandom_range(1, 0)), 8'($urandom), 1'($urandom_range(1, 0)), 8'($urandom), 1'b1, acc);
    look(8'h00); look(8'h7F); look(8'hFF);

    // Lookup of idx 9 every cycle across its RMW: before and in the write cycle
    upd(8'd9, 1'b1);
    for (int i = 0; i < 6; i++) look(8'd9);

    // Saturation up on idx 5, down on idx 20
    for (int i = 0; i < 3; i++) begin upd(8'd5, 1'b1); idle(3); end
    look(8'd5);
    upd(8'd5, 1'b1); idle(4); look(8'd5);
    for (int i = 0; i < 4; i++) begin upd(8'd20, 1'b0); idle(3); end
    look(8'd20);

    // Back-to-back updates of one index exercise RMW forwarding
    upd(8'd7, 1'b1); upd(8'd7, 1'b1);
    idle(8); look(8'd7);

    // Burst of updates held until accepted: fills the FIFO
    for (int i = 0; i < 12; i++) begin
      b_idx[i] = 8'($urandom_range(7, 0));
      b_t[i]   = 1'($urandom_range(1, 0));
    end
    k = 0;
    for (int guard = 0; guard < 100 && k < 12; guard++) begin
      cyc(1'($urandom_range(1, 0)), 8'($urandom_range(7, 0)), 1'b1, b_idx[k], b_t[k], acc);
      if (acc) k++;
    end
    chk("burst_accepted", 32'(k), 32'(12));
    idle(12);
    for (int i = 0; i < 8; i++) look(8'(i));

    // Random mixed traffic on a small index range
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(1, 0)), 8'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
          8'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), acc);
    idle(12);
    for (int i = 0; i < 16; i++) look(8'(i));

    // Reset with updates queued: everything dropped, sweep reruns
    k = 0;
    for (int guard = 0; guard < 20 && q.size() < 3; guard++) begin
      cyc(1'b1, 8'd3, 1'b1, 8'(guard), 1'b1, acc);
      k = q.size();
    end
    chk("queued_before_reset", 32'(k), 32'(3));
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrun");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mc = 1;
    idle(130);
    for (int i = 0; i < 256; i++) look(8'(i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
